// File: rtl/mouse_input_conditioner.sv
// Mouse input conditioning: clamps raw cursor coordinates, debounces both buttons
// into single-cycle click pulses and latches the cursor position of each left click.

module mouse_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic held
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;
    logic             sync_meta, sync_s;

    // Raw level is asynchronous to clk, so it is brought in through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
        end
    end

    // The counter only advances while a level is pending; leaving the state ends it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (sync_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign held = (state_q == PRESSED) || (state_q == DEB_REL);

endmodule

module mouse_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos_raw,
    input  logic [11:0] mouse_ypos_raw,
    input  logic        left_raw,
    input  logic        right_raw,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        left_mouse,
    output logic        right_mouse,
    output logic        left_held,
    output logic        right_held,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos
);

    localparam logic [11:0] X_LIMIT = 12'(X_MAX);
    localparam logic [11:0] Y_LIMIT = 12'(Y_MAX);

    logic [11:0] x_clamped, y_clamped;

    assign x_clamped = (mouse_xpos_raw > X_LIMIT) ? X_LIMIT : mouse_xpos_raw;
    assign y_clamped = (mouse_ypos_raw > Y_LIMIT) ? Y_LIMIT : mouse_ypos_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mouse_xpos <= '0;
            mouse_ypos <= '0;
        end else begin
            mouse_xpos <= x_clamped;
            mouse_ypos <= y_clamped;
        end
    end

    // Shot position takes the same clamped value the coordinate registers load in the pulse cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shot_xpos <= '0;
            shot_ypos <= '0;
        end else if (left_mouse) begin
            shot_xpos <= x_clamped;
            shot_ypos <= y_clamped;
        end
    end

    mouse_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk  (clk),
        .rst  (rst),
        .raw  (left_raw),
        .pulse(left_mouse),
        .held (left_held)
    );

    mouse_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk  (clk),
        .rst  (rst),
        .raw  (right_raw),
        .pulse(right_mouse),
        .held (right_held)
    );

endmodule

// File: tb/tb_mouse_input_conditioner.sv
// Directed bench for mouse_input_conditioner with DEBOUNCE_CYCLES = 8,
// so a clean press yields its pulse 11 cycles after the raw edge.
`timescale 1ns/1ps

module tb_mouse_input_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos_raw, mouse_ypos_raw;
    logic        left_raw, right_raw;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        left_mouse, right_mouse, left_held, right_held;
    logic [11:0] shot_xpos, shot_ypos;

    int vectors = 0;
    int miscompares = 0;

    int l_count, l_first, r_count, r_first;
    logic l_held_at_pulse;

    typedef struct {
        logic [11:0] x_raw;
        logic [11:0] y_raw;
        logic [11:0] exp_x;
        logic [11:0] exp_y;
    } clamp_vec_t;

    clamp_vec_t vecs[7];

    mouse_input_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .X_MAX(1023),
        .Y_MAX(767)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mouse_xpos_raw(mouse_xpos_raw),
        .mouse_ypos_raw(mouse_ypos_raw),
        .left_raw      (left_raw),
        .right_raw     (right_raw),
        .mouse_xpos    (mouse_xpos),
        .mouse_ypos    (mouse_ypos),
        .left_mouse    (left_mouse),
        .right_mouse   (right_mouse),
        .left_held     (left_held),
        .right_held    (right_held),
        .shot_xpos     (shot_xpos),
        .shot_ypos     (shot_ypos)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] x, input logic [11:0] y);
        mouse_xpos_raw = x;
        mouse_ypos_raw = y;
    endtask

    // Steps n cycles, recording pulse counts and the first pulse cycle (1-based) per button.
    task automatic run_cycles(input int n);
        l_count = 0; r_count = 0; l_first = -1; r_first = -1; l_held_at_pulse = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (left_mouse) begin
                if (l_first < 0) begin
                    l_first = k;
                    l_held_at_pulse = left_held;
                end
                l_count++;
            end
            if (right_mouse) begin
                if (r_first < 0) r_first = k;
                r_count++;
            end
        end
    endtask

    initial begin
        int bounce_pulses;
        int shot_first;
        vecs[0] = '{12'd1500, 12'd900,  12'd1023, 12'd767};
        vecs[1] = '{12'd0,    12'd0,    12'd0,    12'd0};
        vecs[2] = '{12'd1023, 12'd767,  12'd1023, 12'd767};
        vecs[3] = '{12'd1024, 12'd768,  12'd1023, 12'd767};
        vecs[4] = '{12'd4095, 12'd4095, 12'd1023, 12'd767};
        vecs[5] = '{12'd500,  12'd300,  12'd500,  12'd300};
        vecs[6] = '{12'd1022, 12'd766,  12'd1022, 12'd766};

        // Reset held with a button pressed: everything stays cleared.
        rst = 1'b0;
        left_raw = 1'b1;
        right_raw = 1'b0;
        apply_stimulus(12'd500, 12'd300);
        repeat (4) step();
        check_output("reset mouse_xpos", int'(mouse_xpos), 0);
        check_output("reset mouse_ypos", int'(mouse_ypos), 0);
        check_output("reset left_mouse", int'(left_mouse), 0);
        check_output("reset left_held", int'(left_held), 0);
        check_output("reset shot_xpos", int'(shot_xpos), 0);
        rst = 1'b1;
        run_cycles(20);
        check_output("post-reset left pulse count", l_count, 1);
        check_output("post-reset left pulse cycle", l_first, 11);
        check_output("post-reset shot_xpos", int'(shot_xpos), 500);
        left_raw = 1'b0;
        run_cycles(10);
        check_output("release held at +10", int'(left_held), 1);
        step();
        check_output("release held at +11", int'(left_held), 0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].x_raw, vecs[i].y_raw);
            step();
            check_output($sformatf("clamp x vec%0d", i), int'(mouse_xpos), int'(vecs[i].exp_x));
            check_output($sformatf("clamp y vec%0d", i), int'(mouse_ypos), int'(vecs[i].exp_y));
        end

        // Clean press held for 100 cycles.
        left_raw = 1'b1;
        run_cycles(100);
        check_output("clean press pulse count", l_count, 1);
        check_output("clean press pulse cycle", l_first, 11);
        check_output("clean press held at pulse", int'(l_held_at_pulse), 1);
        check_output("clean press right pulses", r_count, 0);
        left_raw = 1'b0;
        run_cycles(10);
        check_output("clean release pulses", l_count, 0);
        check_output("clean release held at +10", int'(left_held), 1);
        step();
        check_output("clean release held at +11", int'(left_held), 0);

        // Press bounce: 3-cycle phases, ending low, then a final rising edge.
        bounce_pulses = 0;
        for (int p = 0; p < 10; p++) begin
            left_raw = (p % 2 == 0);
            run_cycles(3);
            bounce_pulses += l_count;
        end
        check_output("press bounce pulses", bounce_pulses, 0);
        left_raw = 1'b1;
        run_cycles(30);
        check_output("post-bounce pulse count", l_count, 1);
        check_output("post-bounce pulse cycle", l_first, 11);
        bounce_pulses = 0;
        for (int p = 0; p < 10; p++) begin
            left_raw = (p % 2 == 1);
            run_cycles(3);
            bounce_pulses += l_count;
        end
        check_output("release bounce held", int'(left_held), 1);
        left_raw = 1'b0;
        run_cycles(20);
        bounce_pulses += l_count;
        check_output("release bounce pulses", bounce_pulses, 0);
        check_output("release bounce held settled", int'(left_held), 0);

        // Shot latch with x ramping +1 per cycle from 100.
        apply_stimulus(12'd100, 12'd200);
        left_raw = 1'b1;
        shot_first = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (left_mouse && shot_first < 0) shot_first = k;
            if (k == 12) check_output("shot_xpos after pulse", int'(shot_xpos), 111);
            mouse_xpos_raw = mouse_xpos_raw + 12'd1;
        end
        check_output("ramp pulse cycle", shot_first, 11);
        check_output("shot_xpos holds", int'(shot_xpos), 111);
        check_output("shot_ypos", int'(shot_ypos), 200);
        left_raw = 1'b0;
        run_cycles(15);

        // Right press must not touch the shot registers.
        apply_stimulus(12'd700, 12'd250);
        right_raw = 1'b1;
        run_cycles(20);
        check_output("right pulse count", r_count, 1);
        check_output("right pulse cycle", r_first, 11);
        check_output("right leaves left idle", l_count, 0);
        check_output("shot_xpos after right", int'(shot_xpos), 111);
        right_raw = 1'b0;
        run_cycles(15);
        check_output("right_held after release", int'(right_held), 0);

        // Simultaneous press.
        left_raw = 1'b1;
        right_raw = 1'b1;
        run_cycles(20);
        check_output("simul left count", l_count, 1);
        check_output("simul right count", r_count, 1);
        check_output("simul left cycle", l_first, 11);
        check_output("simul right cycle", r_first, 11);
        check_output("simul shot_xpos", int'(shot_xpos), 700);
        check_output("simul shot_ypos", int'(shot_ypos), 250);
        left_raw = 1'b0;
        right_raw = 1'b0;
        run_cycles(15);

        // Reset in the middle of a press debounce restarts it.
        left_raw = 1'b1;
        run_cycles(6);
        check_output("pre-reset no pulse", l_count, 0);
        rst = 1'b0;
        step();
        check_output("mid reset held", int'(left_held), 0);
        check_output("mid reset mouse_xpos", int'(mouse_xpos), 0);
        rst = 1'b1;
        run_cycles(20);
        check_output("restart pulse count", l_count, 1);
        check_output("restart pulse cycle", l_first, 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
